// File: rtl/sm_add_sched_if.sv
// sm_add_sched_if: bundles the two requester handshakes, the result
// handshake and the busy flag of the shared sign-magnitude adder scheduler.
// The master side drives operands and res_ready. The slave side is the
// scheduler itself.
interface sm_add_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;

    logic       res_valid;
    logic       res_ready;
    logic [8:0] res_sum;
    logic       res_id;

    logic       busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_sum, res_id,
        output res_ready,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_sum, res_id,
        input  res_ready,
        output busy
    );
endinterface

// File: rtl/sm_add_sched.sv
// sm_add_sched: round-robin scheduler sharing one 8-bit sign-magnitude adder
// between two requesters. A granted operand pair is latched in IDLE, summed
// in EXEC and presented as a registered 9-bit result tagged with the
// requester id in RESP.
// Build option: define SM_SCHED_SMOUT_EN to present res_sum as 9-bit
// sign-magnitude (bit 8 sign, bits 7:0 magnitude). Otherwise res_sum is
// 9-bit two's complement.
module sm_add_sched (
    input  logic          clk,
    input  logic          rst,
    sm_add_sched_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       id_q;
    logic [8:0] sum_q;
    logic       res_id_q;

    logic       grant0;
    logic       grant1;
    logic [8:0] a_tc;
    logic [8:0] b_tc;
    logic [8:0] sum_tc;
    logic [8:0] sum_next;

    // Round-robin grant: a lone requester always wins, a tie goes to the
    // requester that was not served last. Nothing is granted outside IDLE
    // or while reset is held.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Datapath: convert both latched operands to two's complement (negative
    // zero collapses to zero naturally) and add; optionally convert back to
    // sign-magnitude. The range -254..+254 cannot overflow 9 bits.
    always_comb begin
        a_tc   = a_q[7] ? (9'd0 - {2'b00, a_q[6:0]}) : {2'b00, a_q[6:0]};
        b_tc   = b_q[7] ? (9'd0 - {2'b00, b_q[6:0]}) : {2'b00, b_q[6:0]};
        sum_tc = a_tc + b_tc;
`ifdef SM_SCHED_SMOUT_EN
        // |sum| <= 254 fits in 8 bits, so negating the low byte is enough.
        sum_next = sum_tc[8] ? {1'b1, 8'd0 - sum_tc[7:0]} : {1'b0, sum_tc[7:0]};
`else
        sum_next = sum_tc;
`endif
    end

    // Control FSM plus operand and result registers; reset discards any
    // operation in flight and restores the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            id_q       <= 1'b0;
            sum_q      <= 9'd0;
            res_id_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        a_q        <= grant1 ? bus.req1_a : bus.req0_a;
                        b_q        <= grant1 ? bus.req1_b : bus.req0_b;
                        id_q       <= grant1;
                        last_grant <= grant1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    sum_q    <= sum_next;
                    res_id_q <= id_q;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.res_valid = (state == ST_RESP);
    assign bus.res_sum   = sum_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sm_add_sched.sv
// tb_sm_add_sched: table-driven vectors plus hand-written sequences for
// arbitration, backpressure and mid-operation reset. Expected results are
// queued when a request is accepted and compared when the result is taken.
module tb_sm_add_sched;
`ifdef SM_SCHED_SMOUT_EN
    localparam bit SMOUT = 1'b1;
`else
    localparam bit SMOUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    sm_add_sched_if bus ();

    sm_add_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] sum;
        logic       id;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] tc;
        logic [8:0] sm;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sum computed with plain integers.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        int va;
        int vb;
        int s;
        va = int'(a[6:0]);
        if (a[7]) va = -va;
        vb = int'(b[6:0]);
        if (b[7]) vb = -vb;
        s = va + vb;
        if (SMOUT) return {(s < 0) ? 1'b1 : 1'b0, 8'((s < 0) ? -s : s)};
        return 9'(s);
    endfunction

    // Result monitor: samples just before the rising edge, checks ready
    // exclusivity and scores every accepted result against the queue.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            check("ready_onehot", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
            if (bus.res_valid && bus.res_ready) begin
                check("result_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_sum", {23'b0, bus.res_sum}, {23'b0, e.sum});
                    check("res_id", {31'b0, bus.res_id}, {31'b0, e.id});
                end
            end
        end
    end

    task automatic drive_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Single request with res_ready high; checks the accept/EXEC/RESP timing.
    task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input string tag);
        int n;
        @(negedge clk);
        drive_req(id, 1'b1, a, b);
        #3;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({tag, "_grant"}, {31'b0, n < 20}, 32'd1);
        sb.push_back('{sum: exp, id: id});
        @(negedge clk);
        drive_req(id, 1'b0, 8'h00, 8'h00);
        #1;
        check({tag, "_exec_busy"}, {31'b0, bus.busy}, 32'd1);
        check({tag, "_exec_valid"}, {31'b0, bus.res_valid}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_resp_valid"}, {31'b0, bus.res_valid}, 32'd1);
        @(negedge clk);
        #1;
        check({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_idle_valid"}, {31'b0, bus.res_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   n;
        bit   g;
        logic [7:0] a0, b0, a1, b1;

        vecs[0] = '{a: 8'h05, b: 8'h83, tc: 9'h002, sm: 9'h002};
        vecs[1] = '{a: 8'h85, b: 8'h83, tc: 9'h1F8, sm: 9'h108};
        vecs[2] = '{a: 8'h7F, b: 8'h7F, tc: 9'h0FE, sm: 9'h0FE};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, tc: 9'h102, sm: 9'h1FE};
        vecs[4] = '{a: 8'h80, b: 8'h00, tc: 9'h000, sm: 9'h000};
        vecs[5] = '{a: 8'h00, b: 8'h80, tc: 9'h000, sm: 9'h000};
        vecs[6] = '{a: 8'h80, b: 8'h80, tc: 9'h000, sm: 9'h000};
        vecs[7] = '{a: 8'h05, b: 8'h85, tc: 9'h000, sm: 9'h000};
        vecs[8] = '{a: 8'h01, b: 8'h82, tc: 9'h1FF, sm: 9'h101};
        vecs[9] = '{a: 8'h7F, b: 8'hFF, tc: 9'h000, sm: 9'h000};

        rst = 1'b1;
        bus.res_ready = 1'b1;
        drive_req(1'b0, 1'b1, 8'h12, 8'h34);
        drive_req(1'b1, 1'b1, 8'h56, 8'h78);
        #12;
        check("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        check("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_res_sum", {23'b0, bus.res_sum}, 32'd0);
        check("rst_res_id", {31'b0, bus.res_id}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, alternating requesters.
        for (int i = 0; i < 10; i++) begin
            do_op(i[0], vecs[i].a, vecs[i].b, SMOUT ? vecs[i].sm : vecs[i].tc, $sformatf("vec%0d", i));
        end

        // Arbitration: both valid continuously from reset.
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        a0 = 8'h10; b0 = 8'h81; a1 = 8'h92; b1 = 8'h03;
        drive_req(1'b0, 1'b1, a0, b0);
        drive_req(1'b1, 1'b1, a1, b1);
        #1;
        check("arb_rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        check("arb_rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3;
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
                @(negedge clk);
                #3;
                n++;
            end
            check("arb_grant_seen", {31'b0, n < 20}, 32'd1);
            g = bus.req1_ready;
            check($sformatf("arb_order%0d", k), {31'b0, g}, {31'b0, k[0]});
            sb.push_back('{sum: g ? model(a1, b1) : model(a0, b0), id: g});
            @(negedge clk);
            if (g) begin
                a1 = 8'($urandom); b1 = 8'($urandom);
                drive_req(1'b1, 1'b1, a1, b1);
            end else begin
                a0 = 8'($urandom); b0 = 8'($urandom);
                drive_req(1'b0, 1'b1, a0, b0);
            end
        end
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        // req1 alone with the pointer already favouring req0.
        do_op(1'b1, 8'h44, 8'h22, model(8'h44, 8'h22), "solo1");

        // Backpressure: hold res_ready low for 5 RESP cycles.
        @(negedge clk);
        bus.res_ready = 1'b0;
        drive_req(1'b0, 1'b1, 8'h23, 8'h91);
        #3;
        check("bp_grant", {31'b0, bus.req0_ready}, 32'd1);
        sb.push_back('{sum: 9'h012, id: 1'b0});
        @(negedge clk);
        drive_req(1'b1, 1'b1, 8'h01, 8'h01);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", {31'b0, bus.res_valid}, 32'd1);
            check("bp_sum", {23'b0, bus.res_sum}, 32'h012);
            check("bp_id", {31'b0, bus.res_id}, 32'd0);
            check("bp_ready0", {31'b0, bus.req0_ready}, 32'd0);
            check("bp_ready1", {31'b0, bus.req1_ready}, 32'd0);
            check("bp_busy", {31'b0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 8'h00, 8'h00);
        bus.res_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_busy", {31'b0, bus.busy}, 32'd0);
        check("bp_release_valid", {31'b0, bus.res_valid}, 32'd0);

        // Reset during EXEC of a req0 operation.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 8'h11, 8'h22);
        #3;
        check("abort_grant", {31'b0, bus.req0_ready}, 32'd1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_valid", {31'b0, bus.res_valid}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_sum", {23'b0, bus.res_sum}, 32'd0);
        check("abort_id", {31'b0, bus.res_id}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("abort_hold_valid", {31'b0, bus.res_valid}, 32'd0);
        end
        drive_req(1'b0, 1'b1, 8'h0A, 8'h0B);
        drive_req(1'b1, 1'b1, 8'h0C, 8'h0D);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("post_rst_tie_req0", {31'b0, bus.req0_ready}, 32'd1);
        check("post_rst_tie_req1", {31'b0, bus.req1_ready}, 32'd0);
        sb.push_back('{sum: model(8'h0A, 8'h0B), id: 1'b0});
        @(negedge clk);
        drive_req(1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 8'h00, 8'h00);
        repeat (4) @(negedge clk);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
